// File: rtl/alu_issue_ctrl_if.sv
// Request/response, host register-file and ALU handshake bundle for alu_issue_ctrl.
// slave is the controller's view; master is the requester/ALU/host side.
`timescale 1ns/1ps

interface alu_issue_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [2:0]  req_rd;
  logic [2:0]  req_rs1;
  logic [2:0]  req_rs2;

  logic        resp_valid;
  logic        resp_err;
  logic [3:0]  resp_flags;

  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;

  logic        alu_begin;
  logic [13:0] alu_sel;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic        alu_end;
  logic [15:0] alu_out;
  logic        alu_out_active;
  logic        alu_co;
  logic        alu_z;
  logic        alu_v;
  logic        alu_n;

  modport slave (
    input  req_valid, req_op, req_rd, req_rs1, req_rs2,
    output req_ready,
    output resp_valid, resp_err, resp_flags,
    input  wr_en, wr_addr, wr_data, rf_raddr,
    output rf_rdata,
    output alu_begin, alu_sel, alu_in1, alu_in2,
    input  alu_end, alu_out, alu_out_active, alu_co, alu_z, alu_v, alu_n
  );

  modport master (
    output req_valid, req_op, req_rd, req_rs1, req_rs2,
    input  req_ready,
    input  resp_valid, resp_err, resp_flags,
    output wr_en, wr_addr, wr_data, rf_raddr,
    input  rf_rdata,
    input  alu_begin, alu_sel, alu_in1, alu_in2,
    output alu_end, alu_out, alu_out_active, alu_co, alu_z, alu_v, alu_n
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Operand issue / writeback sequencer in front of the 16-bit multi-cycle ALU, with an 8x16 register file.
// Optional ALU_ISSUE_TIMEOUT_EN adds a 10-bit watchdog over the WAIT and RELEASE states.
`timescale 1ns/1ps

module alu_issue_ctrl (
  input  logic           clk,
  input  logic           rst_b,
  alu_issue_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, WAIT, RELEASE, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        err_q;
  logic        err_nxt;
  logic [3:0]  op_q;
  logic [2:0]  rd_q;
  logic [15:0] in1_q;
  logic [15:0] in2_q;
  logic [3:0]  flags_q;
  logic [1:0]  cap_cnt;
  logic [15:0] rf [8];

  logic        accept;
  logic        legal;
  logic        busy;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic        latch_flags;
  logic        tmo;

  assign accept      = bus.req_valid && (state == IDLE);
  assign legal       = (bus.req_op < 4'd14);
  assign busy        = (state == START) || (state == WAIT) || (state == RELEASE);
  assign wb_en       = busy && bus.alu_out_active && (cap_cnt != 2'd2);
  assign wb_addr     = (cap_cnt == 2'd0) ? rd_q : rd_q + 3'd1;
  assign latch_flags = (state == WAIT) && bus.alu_end && !tmo;

`ifdef ALU_ISSUE_TIMEOUT_EN
  logic [9:0] wdog;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wdog <= '0;
    end else if (accept) begin
      wdog <= '0;
    end else if ((state == WAIT) || (state == RELEASE)) begin
      wdog <= wdog + 10'd1;
    end
  end

  assign tmo = ((state == WAIT) || (state == RELEASE)) && (wdog == 10'd1023);
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
    end
  end

  // A watchdog expiry overrides whatever the ALU handshake is doing.
  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    case (state)
      IDLE: begin
        if (accept) begin
          err_nxt   = !legal;
          state_nxt = legal ? START : DONE;
        end
      end
      START:   state_nxt = WAIT;
      WAIT: begin
        if (tmo) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else if (bus.alu_end) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (tmo) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else if (!bus.alu_end) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      op_q    <= '0;
      rd_q    <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      cap_cnt <= '0;
      flags_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= bus.req_op;
        rd_q  <= bus.req_rd;
        in1_q <= rf[bus.req_rs1];
        in2_q <= rf[bus.req_rs2];
      end
      if (accept) begin
        cap_cnt <= '0;
      end else if (wb_en) begin
        cap_cnt <= cap_cnt + 2'd1;
      end
      if (latch_flags) begin
        flags_q <= {bus.alu_co, bus.alu_z, bus.alu_v, bus.alu_n};
      end
    end
  end

  // Writeback is applied after the host write so it wins on an address collision.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 8; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (bus.wr_en) begin
        rf[bus.wr_addr] <= bus.wr_data;
      end
      if (wb_en) begin
        rf[wb_addr] <= bus.alu_out;
      end
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == DONE);
  assign bus.resp_err   = (state == DONE) && err_q;
  assign bus.resp_flags = flags_q;
  assign bus.rf_rdata   = rf[bus.rf_raddr];
  assign bus.alu_begin  = (state == START) || (state == WAIT);
  assign bus.alu_sel    = busy ? (14'd1 << op_q) : 14'd0;
  assign bus.alu_in1    = in1_q;
  assign bus.alu_in2    = in2_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: scripted ALU responder, per-operation timeline model,
// per-cycle compare process and a few literal pins. Define ALU_ISSUE_TIMEOUT_EN to also run the timeout case.
`timescale 1ns/1ps

module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic rst_b = 1'b1;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference state: register file, flags, and the expected outputs for the current cycle.
  logic [15:0] mrf [8];
  logic [3:0]  mflags;
  logic        expReady, expBegin, expValid, expErr;
  logic [13:0] expSel;
  logic [15:0] expIn1, expIn2;

  // Updates sampled at the coming rising edge, applied to the model right after it.
  logic        pendHostEn, pendWbEn, pendFlagEn;
  logic [2:0]  pendHostAddr, pendWbAddr;
  logic [15:0] pendHostData, pendWbData;
  logic [3:0]  pendFlags;

  bit chkEn = 0;
  bit hostRand = 0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Compares every DUT output against the model for the current cycle.
  task automatic checkOutput();
    checkVal("req_ready",  32'(bus.req_ready),  32'(expReady));
    checkVal("alu_begin",  32'(bus.alu_begin),  32'(expBegin));
    checkVal("alu_sel",    32'(bus.alu_sel),    32'(expSel));
    checkVal("resp_valid", 32'(bus.resp_valid), 32'(expValid));
    if (expValid) checkVal("resp_err", 32'(bus.resp_err), 32'(expErr));
    checkVal("resp_flags", 32'(bus.resp_flags), 32'(mflags));
    if (expSel != 14'd0) begin
      checkVal("alu_in1", 32'(bus.alu_in1), 32'(expIn1));
      checkVal("alu_in2", 32'(bus.alu_in2), 32'(expIn2));
    end
    checkVal("rf_rdata", 32'(bus.rf_rdata), 32'(mrf[bus.rf_raddr]));
  endtask

  always @(negedge clk) if (chkEn) checkOutput();

  // Advances to the next cycle: commit model updates, then drive idle defaults plus random noise.
  task automatic nextCycle();
    @(posedge clk);
    if (pendHostEn) mrf[pendHostAddr] = pendHostData;
    if (pendWbEn)   mrf[pendWbAddr]   = pendWbData;
    if (pendFlagEn) mflags = pendFlags;
    pendHostEn = 0; pendWbEn = 0; pendFlagEn = 0;
    #1;
    expReady = 1; expBegin = 0; expSel = '0; expValid = 0; expErr = 0;
    bus.req_valid = 0;
    bus.req_op  = 4'($urandom);
    bus.req_rd  = 3'($urandom);
    bus.req_rs1 = 3'($urandom);
    bus.req_rs2 = 3'($urandom);
    bus.alu_end = 0;
    bus.alu_out_active = 0;
    bus.alu_out = 16'($urandom);
    {bus.alu_co, bus.alu_z, bus.alu_v, bus.alu_n} = 4'($urandom);
    bus.rf_raddr = 3'($urandom);
    bus.wr_en = 0;
    bus.wr_addr = 3'($urandom);
    bus.wr_data = 16'($urandom);
    if (hostRand && $urandom_range(0, 3) == 0) begin
      bus.wr_en = 1;
      pendHostEn = 1; pendHostAddr = bus.wr_addr; pendHostData = bus.wr_data;
    end
  endtask

  task automatic hostWrite(input logic [2:0] addr, input logic [15:0] data);
    bus.wr_en = 1; bus.wr_addr = addr; bus.wr_data = data;
    pendHostEn = 1; pendHostAddr = addr; pendHostData = data;
    nextCycle();
  endtask

  task automatic checkReg(input string name, input logic [2:0] addr, input logic [15:0] lit);
    bus.rf_raddr = addr;
    #0.5;
    checkVal(name, 32'(bus.rf_rdata), 32'(lit));
  endtask

  // Asserts reset mid-cycle, pins the reset state with literals, then releases before the next edge.
  task automatic doReset();
    chkEn = 0;
    #1 rst_b = 0;
    #0.5;
    checkVal("rst_req_ready",  32'(bus.req_ready),  32'd1);
    checkVal("rst_alu_begin",  32'(bus.alu_begin),  32'd0);
    checkVal("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkVal("rst_resp_err",   32'(bus.resp_err),   32'd0);
    checkVal("rst_alu_sel",    32'(bus.alu_sel),    32'd0);
    checkVal("rst_alu_in1",    32'(bus.alu_in1),    32'd0);
    checkVal("rst_alu_in2",    32'(bus.alu_in2),    32'd0);
    checkVal("rst_flags",      32'(bus.resp_flags), 32'd0);
    for (int i = 0; i < 8; i++) begin
      bus.rf_raddr = 3'(i);
      #0.25;
      checkVal("rst_rf", 32'(bus.rf_rdata), 32'd0);
    end
    for (int i = 0; i < 8; i++) mrf[i] = '0;
    mflags = '0;
    pendHostEn = 0; pendWbEn = 0; pendFlagEn = 0;
    bus.alu_end = 0; bus.alu_out_active = 0; bus.wr_en = 0; bus.req_valid = 0;
    expReady = 1; expBegin = 0; expSel = '0; expValid = 0; expErr = 0;
    @(negedge clk);
    #1 rst_b = 1;
    chkEn = 1;
  endtask

  // Issues one request from an idle cycle. Cycle k counts from the accepting edge:
  // ALU asserts alu_end for cycles 1+w..w+h, so DONE falls on cycle 2+w+h.
  // Active cycles come from actMask; the nth word uses d0/d1/d2.
  task automatic applyStimulus(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                               input logic [2:0] rs2, input int w, input int h,
                               input logic [15:0] actMask, input logic [15:0] d0,
                               input logic [15:0] d1, input logic [15:0] d2,
                               input bit addModel, input bit tmo, input int rstAt);
    logic legal;
    int D, nAct;
    logic [15:0] a1, a2, dat, res;
    logic [3:0] fl;
    logic c;
    legal = (op < 4'd14);
    a1 = mrf[rs1];
    a2 = mrf[rs2];
    bus.req_valid = 1; bus.req_op = op; bus.req_rd = rd; bus.req_rs1 = rs1; bus.req_rs2 = rs2;
    D = legal ? 2 + w + h : 0;
    nAct = 0;
    for (int k = 0; k <= D; k++) begin
      nextCycle();
      bus.req_valid = 1'($urandom);
      expReady = 0;
      expValid = (k == D);
      expErr   = (k == D) && (!legal || tmo);
      expBegin = legal && (k <= 1 + w);
      expSel   = (legal && k <= 1 + w + h) ? (14'd1 << op) : 14'd0;
      expIn1 = a1; expIn2 = a2;
      if (legal && k >= 1 + w && k <= w + h) bus.alu_end = 1;
      if (legal && !tmo && k == 1 + w) begin
        if (addModel) begin
          {c, res} = {1'b0, a1} + {1'b0, a2};
          fl = {c, res == 16'd0, (a1[15] == a2[15]) && (res[15] != a1[15]), res[15]};
        end else begin
          fl = 4'($urandom);
        end
        {bus.alu_co, bus.alu_z, bus.alu_v, bus.alu_n} = fl;
        pendFlagEn = 1; pendFlags = fl;
      end
      if (k < 16 && actMask[k]) begin
        dat = (nAct == 0) ? d0 : (nAct == 1) ? d1 : d2;
        if (addModel) dat = bus.alu_in1 + bus.alu_in2;
        bus.alu_out_active = 1;
        bus.alu_out = dat;
        if (legal && k <= 1 + w + h) begin
          nAct++;
          if (nAct <= 2) begin
            pendWbEn = 1;
            pendWbAddr = (nAct == 2) ? rd + 3'd1 : rd;
            pendWbData = dat;
          end
        end
      end
      if (k == rstAt) begin
        doReset();
        return;
      end
    end
    nextCycle();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mrf[i] = '0;
    mflags = '0;
    pendHostEn = 0; pendWbEn = 0; pendFlagEn = 0;
    bus.req_valid = 0; bus.req_op = '0; bus.req_rd = '0; bus.req_rs1 = '0; bus.req_rs2 = '0;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.rf_raddr = '0;
    bus.alu_end = 0; bus.alu_out = '0; bus.alu_out_active = 0;
    bus.alu_co = 0; bus.alu_z = 0; bus.alu_v = 0; bus.alu_n = 0;
    doReset();
    nextCycle();

    // Add: 0x45 + 0x2A into r3, single result word during the first WAIT cycle.
    hostWrite(3'd1, 16'h0045);
    hostWrite(3'd2, 16'h002A);
    checkReg("preload_r1", 3'd1, 16'h0045);
    applyStimulus(4'd0, 3'd3, 3'd1, 3'd2, 0, 1, 16'h0002, 16'h0, 16'h0, 16'h0, 1, 0, -1);
    checkReg("add_r3", 3'd3, 16'h006F);
    checkVal("add_flags", 32'(bus.resp_flags), 32'h0);

    // Two-word result into r7 wrapping to r0; the third word must be dropped.
    hostWrite(3'd1, 16'h5A5A);
    applyStimulus(4'd2, 3'd7, 3'd3, 3'd4, 2, 2, 16'h000E, 16'h0001, 16'h2345, 16'hBEEF, 0, 0, -1);
    checkReg("wrap_r7", 3'd7, 16'h0001);
    checkReg("wrap_r0", 3'd0, 16'h2345);
    checkReg("wrap_r1", 3'd1, 16'h5A5A);

    // Illegal opcodes: immediate error response, ALU untouched, writes ignored.
    applyStimulus(4'd14, 3'd5, 3'd1, 3'd1, 0, 0, 16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, -1);
    applyStimulus(4'd15, 3'd5, 3'd2, 3'd3, 0, 0, 16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, -1);
    checkReg("illegal_r5", 3'd5, 16'h0000);

    // alu_end held for 5 cycles after alu_begin drops; same-register operands.
    applyStimulus(4'd13, 3'd6, 3'd1, 3'd1, 1, 6, 16'h0010, 16'h1234, 16'h0, 16'h0, 0, 0, -1);
    checkReg("hold_r6", 3'd6, 16'h1234);

    // Randomized operations with background host writes.
    hostRand = 1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) nextCycle();
      applyStimulus(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 3'($urandom),
                    $urandom_range(0, 4), $urandom_range(1, 5), 16'($urandom),
                    16'($urandom), 16'($urandom), 16'($urandom), 0, 0, -1);
    end
    hostRand = 0;

    // Reset pulse during WAIT.
    applyStimulus(4'd5, 3'd2, 3'd0, 3'd1, 4, 1, 16'h0003, 16'hAAAA, 16'h5555, 16'h0, 0, 0, 2);
    nextCycle();
    for (int i = 0; i < 8; i++) checkReg("post_rst_rf", 3'(i), 16'h0000);
    applyStimulus(4'd1, 3'd4, 3'd0, 3'd0, 0, 1, 16'h0001, 16'hC0DE, 16'h0, 16'h0, 0, 0, -1);
    checkReg("post_rst_r4", 3'd4, 16'hC0DE);

`ifdef ALU_ISSUE_TIMEOUT_EN
    // alu_end never arrives: DONE with error 1024 cycles after entering WAIT.
    applyStimulus(4'd3, 3'd2, 3'd0, 3'd0, 1023, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1, -1);
`endif

    nextCycle();
    nextCycle();
    chkEn = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Operand-issue and writeback sequencer that sits directly upstream of the 16-bit multi-cycle ALU. It accepts one operation request at a time, reads both operands from an internal 8x16 register file, drives the ALU `Begin`/`sel`/`in1`/`in2` handshake, and captures result words into the register file while the ALU flags output active. On completion it returns a one-cycle response carrying the ALU condition flags.

## Interface
- Parameters: none. Data width is fixed at 16, register count at 8, and `sel` width at 14.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_b` in 1: asynchronous, active-low reset.
- `req_valid` in 1: operation request.
- `req_ready` out 1: block can accept a request; high only in IDLE.
- `req_op` in 4: opcode 0..13 selects `sel = 1<<op`; 14 and 15 are illegal.
- `req_rd`, `req_rs1`, `req_rs2` in 3 each: destination and source register indices.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_err` out 1: qualifies `resp_valid`; set for an illegal opcode or a timeout.
- `resp_flags` out 4: {co,z,v,n} latched from the ALU; held until the next completion.
- `wr_en` in 1, `wr_addr` in 3, `wr_data` in 16: host preload port.
- `rf_raddr` in 3, `rf_rdata` out 16: combinational observation read port.
- `alu_begin` out 1; `alu_sel` out 14; `alu_in1` out 16; `alu_in2` out 16: drive the ALU.
- `alu_end` in 1; `alu_out` in 16; `alu_out_active` in 1; `alu_co`, `alu_z`, `alu_v`, `alu_n` in 1 each: driven by the ALU.

## Operation
- The state machine has five states: IDLE, START, WAIT, RELEASE, DONE.
- **IDLE.** A request is accepted when `req_valid && req_ready`. On acceptance the block registers the opcode, rd, `rf[rs1]` into `alu_in1` and `rf[rs2]` into `alu_in2`.
  - Legal opcode: go to START.
  - Illegal opcode: go to DONE with error set; the ALU is never started.
- **START.** `alu_begin`=1. Go to WAIT.
- **WAIT.** `alu_begin`=1. When `alu_end`=1, latch the four flags, drop `alu_begin`, and go to RELEASE.
- **RELEASE.** `alu_begin`=0. When `alu_end`=0 (the ALU has returned to idle), go to DONE.
- **DONE.** `resp_valid`=1 for one cycle, then go to IDLE.
- **Outputs to the ALU.** `alu_sel`, `alu_in1` and `alu_in2` are held stable from START through RELEASE. `alu_sel` is 0 in IDLE.
- **Writeback.** In every START/WAIT/RELEASE cycle where `alu_out_active`=1, `alu_out` is written to the register file:
  - first such cycle writes `rd`;
  - second such cycle writes `(rd+1) mod 8`, so a two-word multiply/divide result wraps from index 7 to 0;
  - third and later such cycles are ignored.
  - The capture count clears on acceptance.
- **Host write.** A host write is performed in any state. If it targets the same register as a writeback in the same cycle, the writeback wins.
- **Same-register operands.** When `rs1`=`rs2`, both operands read the same value.
- **Reset.** Reset mid-operation returns to IDLE immediately.
  - Every output is 0 except `req_ready`=1.
  - All register file entries and `resp_flags` are 0.
  - The capture count and the watchdog are cleared.

## Timing
- Acceptance is at edge 0. `alu_begin` first rises after edge 0, while in START.
- Minimum latency from acceptance to `resp_valid` is 4 cycles. This occurs with `alu_end` asserted in the first WAIT cycle and deasserted in the first RELEASE cycle.
- For an illegal opcode, `resp_valid` rises the cycle after acceptance.
- Result words are written at the edge ending the cycle in which `alu_out_active` is sampled high. They are visible on `rf_rdata` in the next cycle.
- `resp_flags` updates at the WAIT→RELEASE edge and is therefore valid before and during `resp_valid`.
- `req_ready` is low from the cycle after acceptance through DONE. The next request can be accepted in the cycle after DONE.

## Configuration
- `ALU_ISSUE_TIMEOUT_EN` defined:
  - a 10-bit watchdog counts cycles spent in WAIT plus RELEASE;
  - when it reaches 1023, `alu_begin` drops and the block goes to DONE with `resp_err`=1;
  - flags are not updated on timeout;
  - the watchdog clears on acceptance.
- Macro undefined: no watchdog exists, and the block waits indefinitely in WAIT or RELEASE.

## Test plan
- **Add.** Preload r1=0x0045 and r2=0x002A. Request op selecting add (ALU model returns in1+in2), rd=3.
  - Require `alu_in1`=0x0045, `alu_in2`=0x002A and `alu_sel` one-hot.
  - Require r3=0x006F, `resp_valid` for one cycle, `resp_err`=0, flags z=0, n=0.
- **Two-word result with wrap.** Multiply model emits 0x0001 then 0x2345 on two `alu_out_active` cycles, rd=7.
  - Require r7=0x0001 and r0=0x2345.
  - A third active cycle must leave r1 unchanged.
- **Illegal opcode.** `req_op`=14.
  - Require `alu_begin` never high, `resp_valid`=1 with `resp_err`=1 one cycle after acceptance, and no register changes.
- **Handshake.** The model holds `alu_end` high for 5 cycles after `alu_begin` drops.
  - Require `resp_valid` only after `alu_end` falls, and `req_ready` low throughout the operation.
- **Reset mid-operation.** Pulse `rst_b` low during WAIT.
  - Require immediate `alu_begin`=0, `req_ready`=1, all registers 0x0000, and flags 0.
- **Timeout, with `ALU_ISSUE_TIMEOUT_EN` defined.** `alu_end` is never asserted.
  - Require `resp_err`=1 with `resp_valid` 1024 cycles after entering WAIT.
